// File: rtl/data_sram_pkg.sv
// data_sram_pkg: shared constants and helpers for the data SRAM responder.
//   MMIO_BASE_DEFAULT : addr[31:16] value selecting the MMIO window.
//   OFF_*             : MMIO register word offsets (addr[11:2]); byte
//                       offsets 0x000/0x004/0x008/0x00C.
//   merge_be()        : byte-lane merge of write data into an old word.
package data_sram_pkg;

    localparam logic [15:0] MMIO_BASE_DEFAULT = 16'hBFAF;

    localparam logic [9:0] OFF_TIMER   = 10'h000;
    localparam logic [9:0] OFF_SCRATCH = 10'h001;
    localparam logic [9:0] OFF_WCOUNT  = 10'h002;
    localparam logic [9:0] OFF_STATUS  = 10'h003;

    function automatic logic [31:0] merge_be(input logic [31:0] old,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  we);
        logic [31:0] r;
        r = old;
        for (int unsigned i = 0; i < 4; i++) begin
            if (we[i]) r[i*8 +: 8] = wdata[i*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/data_sram_slave_if.sv
// data_sram_slave_if: CPU data SRAM request/response bundle.
//   data_sram_en    : access request this cycle
//   data_sram_we    : byte-lane write enables, 0 = read
//   data_sram_addr  : byte address
//   data_sram_wdata : lane-aligned write data
//   data_sram_rdata : read data, valid the cycle after a read request
// Modports: master (CPU side), slave (responder side).
interface data_sram_slave_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
        input  data_sram_rdata
    );

    modport slave (
        input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
        output data_sram_rdata
    );
endinterface

// File: rtl/data_sram_mmio.sv
// data_sram_mmio: MMIO register file of the data SRAM responder.
//   clk, reset : clock, asynchronous active-high reset
//   acc        : MMIO access this cycle (read or write)
//   we         : byte-lane write enables (0 = read)
//   off        : register word offset (addr[11:2])
//   wdata      : write data
//   ram_wr     : pulse for each RAM write access (advances WCOUNT)
//   rd_data    : combinational read data for the current offset
// Macro DATA_SRAM_TIMER_EN: when defined, offset 0x000 is a free-running
// timer; otherwise it reads 0, ignores writes and is still a mapped offset.
module data_sram_mmio
    import data_sram_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        acc,
    input  logic [3:0]  we,
    input  logic [9:0]  off,
    input  logic [31:0] wdata,
    input  logic        ram_wr,
    output logic [31:0] rd_data
);

    logic [31:0] scratch;
    logic [31:0] wcount;
    logic        status;
    logic        mapped;
    logic        wr;

    assign wr = acc && (we != '0);

`ifdef DATA_SRAM_TIMER_EN
    logic [31:0] timer;

    // A write replaces that cycle's increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                        timer <= '0;
        else if (wr && off == OFF_TIMER)  timer <= merge_be(timer, wdata, we);
        else                              timer <= timer + 32'd1;
    end
`endif

    always_comb begin
        rd_data = '0;
        mapped  = 1'b1;
        case (off)
`ifdef DATA_SRAM_TIMER_EN
            OFF_TIMER:   rd_data = timer;
`else
            OFF_TIMER:   rd_data = '0;
`endif
            OFF_SCRATCH: rd_data = scratch;
            OFF_WCOUNT:  rd_data = wcount;
            OFF_STATUS:  rd_data = {31'd0, status};
            default:     mapped  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scratch <= '0;
            wcount  <= '0;
            status  <= 1'b0;
        end else begin
            if (wr && off == OFF_SCRATCH) scratch <= merge_be(scratch, wdata, we);
            if (ram_wr)                   wcount  <= wcount + 32'd1;
            // Only one access per cycle, so set and clear never collide.
            if (acc && !mapped)
                status <= 1'b1;
            else if (wr && off == OFF_STATUS && we[0] && wdata[0])
                status <= 1'b0;
        end
    end

endmodule

// File: rtl/data_sram_slave.sv
// data_sram_slave: responder for the CPU data SRAM port. Decodes each
// request to either a byte-lane-writable word RAM or the MMIO window and
// returns read data registered one cycle later; writes and idle cycles
// leave rdata unchanged.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : data_sram_slave_if.slave (en/we/addr/wdata in, rdata out)
// Parameters: ADDR_W (RAM byte-address bits), MMIO_BASE (addr[31:16] of MMIO).
// Macro DATA_SRAM_TIMER_EN enables the MMIO timer (see data_sram_mmio).
module data_sram_slave
    import data_sram_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter logic [15:0] MMIO_BASE = MMIO_BASE_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    data_sram_slave_if.slave bus
);

    localparam int unsigned DEPTH = 1 << (ADDR_W - 2);

    logic [31:0]       ram [0:DEPTH-1];
    logic [31:0]       rdata_q;
    logic [31:0]       mmio_rd;
    logic [ADDR_W-3:0] idx;
    logic [9:0]        off;
    logic              is_mmio;
    logic              rd;
    logic              wr;
    logic              ram_wr;
    logic              unused_addr;

    assign is_mmio     = (bus.data_sram_addr[31:16] == MMIO_BASE);
    assign idx         = bus.data_sram_addr[ADDR_W-1:2];
    assign off         = bus.data_sram_addr[11:2];
    assign rd          = bus.data_sram_en && (bus.data_sram_we == '0);
    assign wr          = bus.data_sram_en && (bus.data_sram_we != '0);
    assign ram_wr      = wr && !is_mmio;
    assign unused_addr = ^bus.data_sram_addr[1:0];

    data_sram_mmio u_mmio (
        .clk     (clk),
        .reset   (reset),
        .acc     (bus.data_sram_en && is_mmio),
        .we      (bus.data_sram_we),
        .off     (off),
        .wdata   (bus.data_sram_wdata),
        .ram_wr  (ram_wr),
        .rd_data (mmio_rd)
    );

    // Contents are not reset; writes during reset are dropped.
    always_ff @(posedge clk) begin
        if (ram_wr && !reset)
            ram[idx] <= merge_be(ram[idx], bus.data_sram_wdata, bus.data_sram_we);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)   rdata_q <= '0;
        else if (rd) rdata_q <= is_mmio ? mmio_rd : ram[idx];
    end

    assign bus.data_sram_rdata = rdata_q;

endmodule

// File: tb/tb_data_sram_slave.sv
// tb_data_sram_slave: directed vector table for data_sram_slave plus a
// hand-written mid-stream reset sequence. Timer expectations follow
// DATA_SRAM_TIMER_EN (0 when the timer is compiled out).
module tb_data_sram_slave;

`ifdef DATA_SRAM_TIMER_EN
    localparam bit TMR = 1'b1;
`else
    localparam bit TMR = 1'b0;
`endif

    logic clk;
    logic reset;

    data_sram_slave_if bus ();

    data_sram_slave #(.ADDR_W(16), .MMIO_BASE(16'hBFAF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       name;
        logic        en;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [31:0] A_TIMER   = 32'hBFAF_0000;
    localparam logic [31:0] A_SCRATCH = 32'hBFAF_0004;
    localparam logic [31:0] A_WCOUNT  = 32'hBFAF_0008;
    localparam logic [31:0] A_STATUS  = 32'hBFAF_000C;

    task automatic add(input string name, input logic en, input logic [3:0] we,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp);
        vec_t v;
        v.name = name; v.en = en; v.we = we; v.addr = addr; v.wdata = wdata; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: rdata=%h expected=%h", name, act, exp);
        end
    endtask

    // Drive one request for the current cycle and step to the next negedge.
    task automatic drive(input logic en, input logic [3:0] we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        bus.data_sram_en    = en;
        bus.data_sram_we    = we;
        bus.data_sram_addr  = addr;
        bus.data_sram_wdata = wdata;
        @(negedge clk);
    endtask

    function automatic logic [31:0] t(input logic [31:0] v);
        return TMR ? v : 32'd0;
    endfunction

    initial begin
        // Entry k is issued in cycle k after reset release.
        add("idle0",        1'b0, 4'h0, 32'h0,        32'h0,        32'h0);
        add("sw_1c",        1'b1, 4'hF, 32'h1C00_0000, 32'h1234_5678, 32'h0);
        add("lw_1c",        1'b1, 4'h0, 32'h1C00_0000, 32'h0,        32'h1234_5678);
        add("sw_10",        1'b1, 4'hF, 32'h0000_0010, 32'h1111_1111, 32'h1234_5678);
        add("sb_10_lane2",  1'b1, 4'h4, 32'h0000_0010, 32'hAABB_CCDD, 32'h1234_5678);
        add("timer_c5",     1'b1, 4'h0, A_TIMER,      32'h0,        t(32'd5));
        add("lw_10",        1'b1, 4'h0, 32'h0000_0010, 32'h0,        32'h11BB_1111);
        add("lw_alias",     1'b1, 4'h0, 32'h0001_0013, 32'h0,        32'h11BB_1111);
        add("en0_hold",     1'b0, 4'hF, 32'h0000_0010, 32'h0,        32'h11BB_1111);
        add("timer_c9",     1'b1, 4'h0, A_TIMER,      32'h0,        t(32'd9));
        add("lw_10_again",  1'b1, 4'h0, 32'h0000_0010, 32'h0,        32'h11BB_1111);
        add("sw_scratch",   1'b1, 4'hF, A_SCRATCH,    32'hDEAD_BEEF, 32'h11BB_1111);
        add("sb_scratch",   1'b1, 4'h2, A_SCRATCH,    32'h0000_5500, 32'h11BB_1111);
        add("lw_scratch",   1'b1, 4'h0, A_SCRATCH,    32'h0,        32'hDEAD_55EF);
        add("wcount_3",     1'b1, 4'h0, A_WCOUNT,     32'h0,        32'd3);
        add("sw_wcount",    1'b1, 4'hF, A_WCOUNT,     32'h1234_5678, 32'd3);
        add("wcount_ro",    1'b1, 4'h0, A_WCOUNT,     32'h0,        32'd3);
        add("status_0",     1'b1, 4'h0, A_STATUS,     32'h0,        32'd0);
        add("unmapped_40",  1'b1, 4'h0, 32'hBFAF_0040, 32'h0,        32'd0);
        add("status_set",   1'b1, 4'h0, A_STATUS,     32'h0,        32'd1);
        add("sw_timer_c20", 1'b1, 4'hF, A_TIMER,      32'hFFFF_FFFE, 32'd1);
        add("clr_status",   1'b1, 4'h1, A_STATUS,     32'h0000_0001, 32'd1);
        add("timer_c22",    1'b1, 4'h0, A_TIMER,      32'h0,        t(32'hFFFF_FFFF));
        add("timer_wrap",   1'b1, 4'h0, A_TIMER,      32'h0,        t(32'h0));
        add("status_clr",   1'b1, 4'h0, A_STATUS,     32'h0,        32'd0);
        add("timer_c25",    1'b1, 4'h0, A_TIMER,      32'h0,        t(32'd2));
        add("sb_timer",     1'b1, 4'h1, A_TIMER,      32'h0000_00AA, t(32'd2));
        add("status_tmap",  1'b1, 4'h0, A_STATUS,     32'h0,        32'd0);
        add("timer_c28",    1'b1, 4'h0, A_TIMER,      32'h0,        t(32'h0000_00AB));
        add("sw_unmapped",  1'b1, 4'hF, 32'hBFAF_0100, 32'hFFFF_FFFF, t(32'h0000_00AB));
        add("clr_no_we0",   1'b1, 4'h2, A_STATUS,     32'h0000_0101, t(32'h0000_00AB));
        add("status_kept",  1'b1, 4'h0, A_STATUS,     32'h0,        32'd1);
        add("wcount_mmio",  1'b1, 4'h0, A_WCOUNT,     32'h0,        32'd3);
        add("sw_20",        1'b1, 4'hF, 32'h0000_0020, 32'hCAFE_F00D, 32'd3);
        add("lw_20_raw",    1'b1, 4'h0, 32'h0000_0020, 32'h0,        32'hCAFE_F00D);
        add("sb_20_lane3",  1'b1, 4'h8, 32'h0000_0020, 32'h7700_0000, 32'hCAFE_F00D);
        add("lw_20_merge",  1'b1, 4'h0, 32'h0000_0020, 32'h0,        32'h77FE_F00D);
        add("wcount_5",     1'b1, 4'h0, A_WCOUNT,     32'h0,        32'd5);

        reset = 1'b1;
        bus.data_sram_en    = 1'b0;
        bus.data_sram_we    = '0;
        bus.data_sram_addr  = '0;
        bus.data_sram_wdata = '0;
        repeat (2) @(negedge clk);
        check("reset_rdata", bus.data_sram_rdata, 32'h0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            check(vecs[i].name, bus.data_sram_rdata, vecs[i].exp);
        end

        // Reset lands between a read request and its response edge.
        bus.data_sram_en    = 1'b1;
        bus.data_sram_we    = 4'h0;
        bus.data_sram_addr  = 32'h0000_0020;
        #2 reset = 1'b1;
        #1 check("async_reset_now", bus.data_sram_rdata, 32'h0);
        // A write held across reset edges must be dropped.
        bus.data_sram_we    = 4'hF;
        bus.data_sram_wdata = 32'h0;
        @(negedge clk);
        check("reset_held", bus.data_sram_rdata, 32'h0);
        reset = 1'b0;

        drive(1'b1, 4'h0, A_SCRATCH, 32'h0);
        check("rst_scratch", bus.data_sram_rdata, 32'h0);
        drive(1'b1, 4'h0, A_WCOUNT, 32'h0);
        check("rst_wcount", bus.data_sram_rdata, 32'h0);
        drive(1'b1, 4'h0, A_STATUS, 32'h0);
        check("rst_status", bus.data_sram_rdata, 32'h0);
        drive(1'b1, 4'h0, A_TIMER, 32'h0);
        check("rst_timer_c3", bus.data_sram_rdata, t(32'd3));
        drive(1'b1, 4'h0, 32'h0000_0020, 32'h0);
        check("ram_survives", bus.data_sram_rdata, 32'h77FE_F00D);
        drive(1'b0, 4'h0, 32'h0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
